// File: rtl/fir_coeff_loader.sv
// Purpose : turns a framed byte stream (HDR_BYTE, NUM_COEFF big-endian words, XOR checksum) into FIR coefficient writes.
// Latency : one c_WE cycle after the last byte of each word; done/err one cycle after the checksum byte (or timeout).
// Backpressure: s_ready drops in IDLE, WRITE and FIN; an upstream stall longer than TIMEOUT-1 cycles aborts the frame with err.
//
// Ports:
//   clk, nrst               clock, asynchronous active-low reset
//   start                   begin a load (only honoured in IDLE)
//   s_valid/s_ready/s_data  byte stream in, transfer = s_valid & s_ready
//   c_WE/c_in/c_addr        coefficient write port to the FIR (c_in/c_addr hold between writes)
//   busy                    any state other than IDLE
//   done/err                single-cycle result pulses
module fir_coeff_loader #(
    parameter int         ORD        = 256,
    parameter int         COEFF_SIZE = 16,
    parameter logic [7:0] HDR_BYTE   = 8'hA5,
    parameter int         TIMEOUT    = 1024,
    localparam int        NUM_COEFF  = (ORD + 1) >> 1,
    localparam int        ADDR_W     = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  c_WE,
    output logic [COEFF_SIZE-1:0] c_in,
    output logic [ADDR_W-1:0]     c_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int BYTES = COEFF_SIZE / 8;
    localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_COEFF - 1);
    localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(BYTES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        RECV  = 3'd2,
        WRITE = 3'd3,
        CHK   = 3'd4,
        FIN   = 3'd5
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_W-1:0]       idx_q;
    logic [BC_W-1:0]         bcnt_q;
    logic [7:0]              csum_q;
    logic [TO_W-1:0]         to_cnt_q;
    logic [COEFF_SIZE-1:0]   word_q;
    logic [COEFF_SIZE-1:0]   c_in_q;
    logic [ADDR_W-1:0]       c_addr_q;
    logic                    ok_q;

    logic                    xfer;
    logic                    to_hit;
    logic                    waiting;
    logic [COEFF_SIZE-1:0]   word_next;

    assign xfer      = s_valid & s_ready;
    // States that wait on the stream are the only ones that can time out.
    assign waiting   = (state_q == HDR) || (state_q == RECV) || (state_q == CHK);
    assign to_hit    = waiting && !xfer && (to_cnt_q == TO_LAST);
    // MSB-first assembly; the shift also works when a word is a single byte.
    assign word_next = (word_q << 8) | COEFF_SIZE'(s_data);

    assign c_in   = c_in_q;
    assign c_addr = c_addr_q;

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = HDR;
            end
            HDR: begin
                if (xfer && (s_data == HDR_BYTE)) state_d = RECV;
                else if (to_hit)                  state_d = FIN;
            end
            RECV: begin
                if (xfer && (bcnt_q == LAST_BYTE)) state_d = WRITE;
                else if (to_hit)                   state_d = FIN;
            end
            WRITE: begin
                state_d = (idx_q == LAST_IDX) ? CHK : RECV;
            end
            CHK: begin
                if (xfer || to_hit) state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        s_ready = 1'b0;
        c_WE    = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        err     = 1'b0;
        case (state_q)
            IDLE:  busy    = 1'b0;
            HDR:   s_ready = 1'b1;
            RECV:  s_ready = 1'b1;
            WRITE: c_WE    = 1'b1;
            CHK:   s_ready = 1'b1;
            FIN: begin
                done = ok_q;
                err  = ~ok_q;
            end
            default: busy = 1'b0;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            idx_q    <= '0;
            bcnt_q   <= '0;
            csum_q   <= '0;
            to_cnt_q <= '0;
            word_q   <= '0;
            c_in_q   <= '0;
            c_addr_q <= '0;
            ok_q     <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                idx_q    <= '0;
                bcnt_q   <= '0;
                csum_q   <= '0;
                to_cnt_q <= '0;
                ok_q     <= 1'b0;
            end

            // Idle-gap counter: saturates at TO_LAST, where the FSM leaves anyway.
            if (waiting) begin
                if (xfer)                     to_cnt_q <= '0;
                else if (to_cnt_q != TO_LAST) to_cnt_q <= to_cnt_q + 1'b1;
            end

            if (state_q == RECV && xfer) begin
                word_q <= word_next;
                csum_q <= csum_q ^ s_data;
                if (bcnt_q == LAST_BYTE) begin
                    bcnt_q   <= '0;
                    // Output registers are loaded only here, so they change
                    // exactly when the WRITE cycle presents them.
                    c_in_q   <= word_next;
                    c_addr_q <= idx_q;
                end else begin
                    bcnt_q <= bcnt_q + 1'b1;
                end
            end

            if (state_q == WRITE) begin
                idx_q <= idx_q + 1'b1;
            end

            // A timeout leaves ok_q at 0, so FIN reports err.
            if (state_q == CHK && xfer) begin
                ok_q <= (s_data == csum_q);
            end
        end
    end

endmodule

// File: tb/tb_fir_coeff_loader.sv
module tb_fir_coeff_loader;

    localparam int         CS  = 16;
    localparam int         AW  = 7;
    localparam int         NC  = 128;
    localparam logic [7:0] HDR = 8'hA5;

    logic          clk = 1'b0;
    logic          nrst;
    logic          start;
    logic          s_valid;
    logic [7:0]    s_data;
    logic          s_ready;
    logic          c_WE;
    logic [CS-1:0] c_in;
    logic [AW-1:0] c_addr;
    logic          busy;
    logic          done;
    logic          err;

    fir_coeff_loader #(
        .ORD        (256),
        .COEFF_SIZE (CS),
        .HDR_BYTE   (HDR),
        .TIMEOUT    (1024)
    ) dut (
        .clk     (clk),
        .nrst    (nrst),
        .start   (start),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .c_WE    (c_WE),
        .c_in    (c_in),
        .c_addr  (c_addr),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: records every write and counts result pulses, sampled mid-cycle.
    logic [AW-1:0] wa_q[$];
    logic [CS-1:0] wd_q[$];
    int   done_cnt  = 0;
    int   err_cnt   = 0;
    int   b2b_cnt   = 0;
    int   busy_cyc  = 0;
    int   done_mark = 0;
    logic prev_we   = 1'b0;

    always @(negedge clk) begin
        if (c_WE) begin
            wa_q.push_back(c_addr);
            wd_q.push_back(c_in);
            if (prev_we) b2b_cnt <= b2b_cnt + 1;
        end
        prev_we <= c_WE;
        if (busy) busy_cyc <= busy_cyc + 1;
        if (done) begin
            done_cnt  <= done_cnt + 1;
            done_mark <= busy_cyc + 1;
        end
        if (err) err_cnt <= err_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [15:0] coef(input int k);
        logic [15:0] kk;
        kk = k[15:0];
        return 16'h0100 + kk;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Present a byte and hold it until a transfer edge (bounded).
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok      = 1'b0;
        s_valid = 1'b1;
        s_data  = b;
        for (int t = 0; t < 2000 && !ok; t++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        chk("byte_accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic send_word(input int k, input int stall);
        logic [15:0] w;
        w = coef(k);
        send_byte(w[15:8]);
        if (stall > 0) begin
            s_valid = 1'b0;
            tick(stall);
        end
        send_byte(w[7:0]);
    endtask

    // Frame of words 0..last_word; checksum byte only when the frame is complete.
    task automatic run_frame(input bit garbage, input int stall_word, input int stall_len,
                             input bit bad, input int start_word, input int last_word);
        logic [7:0]  cs;
        logic [15:0] w;
        int          base;
        cs   = 8'h00;
        base = wa_q.size();
        pulse_start();
        if (garbage) begin
            send_byte(8'h00);
            send_byte(8'hFF);
            send_byte(8'h5A);
            chk("garbage_no_we", wa_q.size() - base, 0);
            chk("garbage_busy", {31'd0, busy}, 32'd1);
        end
        send_byte(HDR);
        for (int k = 0; k <= last_word; k++) begin
            if (k == start_word) start = 1'b1;
            send_word(k, (k == stall_word) ? stall_len : 0);
            start = 1'b0;
            w  = coef(k);
            cs = cs ^ w[15:8] ^ w[7:0];
        end
        if (last_word == NC - 1) send_byte(bad ? (cs ^ 8'h01) : cs);
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 100 && busy; t++) tick(1);
        chk("busy_fall", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_writes(input int base, input int n);
        chk("wr_count", wa_q.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < wa_q.size()) begin
                chk($sformatf("waddr[%0d]", i), {25'd0, wa_q[base+i]}, i);
                chk($sformatf("wdata[%0d]", i), {16'd0, wd_q[base+i]}, {16'd0, coef(i)});
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_c_WE"},    {31'd0, c_WE},    32'd0);
        chk({tag, "_c_in"},    {16'd0, c_in},    32'd0);
        chk({tag, "_c_addr"},  {25'd0, c_addr},  32'd0);
        chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
        chk({tag, "_busy"},    {31'd0, busy},    32'd0);
        chk({tag, "_done"},    {31'd0, done},    32'd0);
        chk({tag, "_err"},     {31'd0, err},     32'd0);
    endtask

    int base, d0, e0, bsnap, nw;

    initial begin
        nrst    = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        #1;
        check_reset_outputs("rst");
        tick(3);
        nrst = 1'b1;
        tick(2);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // 1: full frame, s_valid held high; 387 busy cycles including FIN.
        base = wa_q.size(); d0 = done_cnt; e0 = err_cnt; bsnap = busy_cyc;
        run_frame(1'b0, -1, 0, 1'b0, -1, NC - 1);
        wait_idle();
        check_writes(base, NC);
        chk("t1_done", done_cnt - d0, 1);
        chk("t1_err", err_cnt - e0, 0);
        chk("t1_frame_cycles", done_mark - bsnap, 387);

        // 2: corrupted checksum.
        base = wa_q.size(); d0 = done_cnt; e0 = err_cnt;
        run_frame(1'b0, -1, 0, 1'b1, -1, NC - 1);
        wait_idle();
        check_writes(base, NC);
        chk("t2_done", done_cnt - d0, 0);
        chk("t2_err", err_cnt - e0, 1);

        // 3: garbage bytes before the header.
        base = wa_q.size(); d0 = done_cnt; e0 = err_cnt;
        run_frame(1'b1, -1, 0, 1'b0, -1, NC - 1);
        wait_idle();
        check_writes(base, NC);
        chk("t3_done", done_cnt - d0, 1);
        chk("t3_err", err_cnt - e0, 0);

        // 4a: 500-cycle stall in the middle of word 5.
        base = wa_q.size(); d0 = done_cnt; e0 = err_cnt;
        run_frame(1'b0, 5, 500, 1'b0, -1, NC - 1);
        wait_idle();
        check_writes(base, NC);
        chk("t4a_done", done_cnt - d0, 1);
        chk("t4a_err", err_cnt - e0, 0);

        // 4b: stream stops after 10 words; timeout fires after 1024 idle RECV cycles.
        base = wa_q.size(); d0 = done_cnt; e0 = err_cnt;
        run_frame(1'b0, -1, 0, 1'b0, -1, 9);
        tick(1020);
        chk("t4b_no_early_err", err_cnt - e0, 0);
        chk("t4b_still_busy", {31'd0, busy}, 32'd1);
        wait_idle();
        check_writes(base, 10);
        chk("t4b_err", err_cnt - e0, 1);
        chk("t4b_done", done_cnt - d0, 0);

        // 5: start asserted while loading word 40 is ignored.
        base = wa_q.size(); d0 = done_cnt; e0 = err_cnt;
        run_frame(1'b0, -1, 0, 1'b0, 40, NC - 1);
        wait_idle();
        check_writes(base, NC);
        chk("t5_done", done_cnt - d0, 1);
        chk("t5_err", err_cnt - e0, 0);

        // 6: reset after word 60 has been written, then a clean reload.
        base = wa_q.size(); d0 = done_cnt; e0 = err_cnt;
        run_frame(1'b0, -1, 0, 1'b0, -1, 60);
        tick(1);
        chk("t6_c_in_hold", {16'd0, c_in}, {16'd0, coef(60)});
        chk("t6_c_addr_hold", {25'd0, c_addr}, 32'd60);
        chk("t6_busy_before", {31'd0, busy}, 32'd1);
        #1 nrst = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        tick(5);
        nw = wa_q.size();
        #2 nrst = 1'b1;
        tick(5);
        chk("t6_no_we_after", wa_q.size() - nw, 0);
        check_writes(base, 61);
        chk("t6_no_result", (done_cnt - d0) + (err_cnt - e0), 0);

        base = wa_q.size(); d0 = done_cnt; e0 = err_cnt;
        run_frame(1'b0, -1, 0, 1'b0, -1, NC - 1);
        wait_idle();
        check_writes(base, NC);
        chk("t6_done", done_cnt - d0, 1);
        chk("t6_err", err_cnt - e0, 0);

        chk("we_back_to_back", b2b_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
